// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Provides rf_wb_pkg: FSM state encoding, default widths, r0 index and a
// saturating counter helper used by the optional statistics block.
`timescale 1ns/1ps
package rf_wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};

    // IDLE: no lu result waiting, WAIT: lu denied at least once,
    // FORCE: single cycle where the pipeline is stalled and lu is granted.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the execute/writeback stages, the long-latency unit,
// decode hazard logic and the register file write port.
// master = surrounding pipeline, slave = the arbiter.
`timescale 1ns/1ps
interface rf_wb_arbiter_if #(
    parameter int DATA_W = rf_wb_pkg::DATA_W,
    parameter int ADDR_W = rf_wb_pkg::ADDR_W
);
    // pipeline writeback
    logic              pipe_wb_valid;
    logic [ADDR_W-1:0] pipe_wb_rd;
    logic [DATA_W-1:0] pipe_wb_data;
    logic              pipe_stall;
    // long-latency unit issue and result handshake
    logic              lu_issue_valid;
    logic [ADDR_W-1:0] lu_issue_rd;
    logic              lu_res_valid;
    logic [ADDR_W-1:0] lu_res_rd;
    logic [DATA_W-1:0] lu_res_data;
    logic              lu_res_ready;
    // decode hazard query
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rs_busy;
    logic              rt_busy;
    // register file write port
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;

    modport master (
        output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        output lu_issue_valid, lu_issue_rd,
        output lu_res_valid, lu_res_rd, lu_res_data,
        output rs_addr, rt_addr,
        input  pipe_stall, lu_res_ready, rs_busy, rt_busy,
        input  rf_wr_en, rf_wr_addr, rf_wr_data
    );

    modport slave (
        input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        input  lu_issue_valid, lu_issue_rd,
        input  lu_res_valid, lu_res_rd, lu_res_data,
        input  rs_addr, rt_addr,
        output pipe_stall, lu_res_ready, rs_busy, rt_busy,
        output rf_wr_en, rf_wr_addr, rf_wr_data
    );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Busy scoreboard for destinations of in-flight long-latency operations.
// A register is marked on issue and released when its result is accepted;
// a same-cycle set and clear of one register leaves it marked. Queries
// bypass the clear happening this cycle because the register file
// forwards the write that is being committed.
`timescale 1ns/1ps
module rf_scoreboard
    import rf_wb_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_rd,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_rd,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;
    logic            rs_clr_s;
    logic            rt_clr_s;

    // Decode the set and clear requests into one-hot masks; r0 is never marked.
    always_comb begin
        set_mask_s = {NREG{1'b0}};
        clr_mask_s = {NREG{1'b0}};
        if (set_en && (set_rd != REG_ZERO[ADDR_W-1:0])) begin
            set_mask_s[set_rd] = 1'b1;
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
        if (clr_en) begin
            clr_mask_s[clr_rd] = 1'b1;
        end else begin
            clr_mask_s = {NREG{1'b0}};
        end
    end

    // Busy vector: clear first, then set, so a simultaneous set wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Hazard queries with same-cycle clear bypass, forced low during reset.
    always_comb begin
        rs_clr_s = clr_en && (clr_rd == rs_addr);
        rt_clr_s = clr_en && (clr_rd == rt_addr);
        if (reset) begin
            rs_busy = 1'b0;
            rt_busy = 1'b0;
        end else begin
            rs_busy = busy_r[rs_addr] & ~rs_clr_s;
            rt_busy = busy_r[rt_addr] & ~rt_clr_s;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter between the pipeline writeback stage
// and a long-latency unit (lu). The pipeline normally wins; after
// STARVE_LIMIT consecutive denials the lu gets a one-cycle forced grant
// while the pipeline is stalled. Also tracks lu destinations for RAW
// hazard detection.
// Optional build macro: RF_WB_STATS_EN adds saturating conflict/force
// counters as extra output ports.
`timescale 1ns/1ps
module rf_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 3
) (
    input  logic           clock,
    input  logic           reset,
    rf_wb_arbiter_if.slave bus
`ifdef RF_WB_STATS_EN
    ,
    output logic [15:0]    conflict_cnt,
    output logic [15:0]    force_cnt
`endif
);

    import rf_wb_pkg::*;

    // Threshold compared against wait_cnt on a denial; 1..15 fits in 4 bits.
    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    logic [3:0] wait_cnt_r;
    logic [3:0] wait_cnt_nxt_s;
    logic       forced_s;
    logic       pipe_grant_s;
    logic       lu_grant_s;
    logic       lu_denied_s;

    // Grant decision: pipe wins unless this is the forced lu cycle.
    always_comb begin
        forced_s     = (state_r == FORCE);
        pipe_grant_s = bus.pipe_wb_valid & ~forced_s;
        lu_grant_s   = bus.lu_res_valid & ~pipe_grant_s;
        lu_denied_s  = bus.lu_res_valid & pipe_grant_s;
    end

    // Next-state and wait counter: count denials, force after the bound.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        if (lu_grant_s) begin
            wait_cnt_nxt_s = 4'd0;
        end else if (lu_denied_s && (wait_cnt_r != 4'hF)) begin
            wait_cnt_nxt_s = wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
        case (state_r)
            IDLE: begin
                // With a limit of one the very first denial already forces.
                if (lu_denied_s) begin
                    if (wait_cnt_r >= LIMIT_M1) begin
                        state_nxt_s = FORCE;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (lu_grant_s) begin
                    state_nxt_s = IDLE;
                end else if (lu_denied_s && (wait_cnt_r >= LIMIT_M1)) begin
                    state_nxt_s = FORCE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            FORCE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register; reset drops any pending grant or wait history.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Zero-latency write port mux and handshake outputs, all low in reset.
    always_comb begin
        bus.rf_wr_en     = 1'b0;
        bus.rf_wr_addr   = bus.pipe_wb_rd;
        bus.rf_wr_data   = bus.pipe_wb_data;
        bus.lu_res_ready = 1'b0;
        bus.pipe_stall   = 1'b0;
        if (reset) begin
            bus.rf_wr_en     = 1'b0;
            bus.lu_res_ready = 1'b0;
            bus.pipe_stall   = 1'b0;
        end else begin
            bus.lu_res_ready = lu_grant_s;
            bus.pipe_stall   = forced_s;
            if (pipe_grant_s) begin
                bus.rf_wr_en   = (bus.pipe_wb_rd != REG_ZERO[ADDR_W-1:0]);
                bus.rf_wr_addr = bus.pipe_wb_rd;
                bus.rf_wr_data = bus.pipe_wb_data;
            end else if (lu_grant_s) begin
                // r0 writes are dropped but the handshake still completes.
                bus.rf_wr_en   = (bus.lu_res_rd != REG_ZERO[ADDR_W-1:0]);
                bus.rf_wr_addr = bus.lu_res_rd;
                bus.rf_wr_data = bus.lu_res_data;
            end else begin
                bus.rf_wr_en = 1'b0;
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clock   (clock),
        .reset   (reset),
        .set_en  (bus.lu_issue_valid),
        .set_rd  (bus.lu_issue_rd),
        .clr_en  (lu_grant_s),
        .clr_rd  (bus.lu_res_rd),
        .rs_addr (bus.rs_addr),
        .rt_addr (bus.rt_addr),
        .rs_busy (bus.rs_busy),
        .rt_busy (bus.rt_busy)
    );

`ifdef RF_WB_STATS_EN
    logic [15:0] conflict_cnt_r;
    logic [15:0] force_cnt_r;

    // Saturating statistics: denied lu cycles and entries into FORCE.
    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_cnt_r <= 16'd0;
            force_cnt_r    <= 16'd0;
        end else begin
            if (lu_denied_s) begin
                conflict_cnt_r <= sat_inc16(conflict_cnt_r);
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
            if ((state_nxt_s == FORCE) && (state_r != FORCE)) begin
                force_cnt_r <= sat_inc16(force_cnt_r);
            end else begin
                force_cnt_r <= force_cnt_r;
            end
        end
    end

    assign conflict_cnt = conflict_cnt_r;
    assign force_cnt    = force_cnt_r;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a transaction-level reference model
// (consecutive-denial count, pending-force flag, busy set) checked every cycle.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;

    localparam int LIMIT = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rf_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

`ifdef RF_WB_STATS_EN
    logic [15:0] conflict_cnt;
    logic [15:0] force_cnt;
`endif

    rf_wb_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
`ifdef RF_WB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .force_cnt    (force_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int        m_denied = 0;     // consecutive denied lu cycles
    bit        m_force  = 1'b0;  // this cycle is the forced lu cycle
    bit [31:0] m_busy   = 32'd0;
    int        m_conf   = 0;
    int        m_fcnt   = 0;
    bit        run      = 1'b0;

    function automatic bit lu_acc();
        return bus.lu_res_valid && (m_force || !bus.pipe_wb_valid);
    endfunction

    // Model update at the clock edge from the inputs of the ending cycle.
    always @(posedge clock) begin
        if (reset) begin
            m_denied <= 0;
            m_force  <= 1'b0;
            m_busy   <= 32'd0;
            m_conf   <= 0;
            m_fcnt   <= 0;
        end else begin
            m_busy <= (m_busy & ~(lu_acc() ? (32'd1 << bus.lu_res_rd) : 32'd0))
                      | ((bus.lu_issue_valid && bus.lu_issue_rd != 5'd0) ? (32'd1 << bus.lu_issue_rd) : 32'd0);
            if (lu_acc()) begin
                m_denied <= 0;
                m_force  <= 1'b0;
            end else if (bus.lu_res_valid) begin
                m_conf   <= m_conf + 1;
                m_denied <= m_denied + 1;
                m_force  <= (m_denied + 1 >= LIMIT);
                if (m_denied + 1 >= LIMIT) m_fcnt <= m_fcnt + 1;
            end else begin
                m_denied <= 0;
                m_force  <= 1'b0;
            end
        end
    end

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clock) begin : cmp
        bit          acc;
        bit          pw;
        bit          en;
        logic [4:0]  addr;
        logic [31:0] data;
        if (run) begin
            acc = !reset && lu_acc();
            pw  = !reset && bus.pipe_wb_valid && !m_force;
            en  = 1'b0;
            addr = 5'd0;
            data = 32'd0;
            if (pw) begin
                en = (bus.pipe_wb_rd != 5'd0); addr = bus.pipe_wb_rd; data = bus.pipe_wb_data;
            end else if (acc) begin
                en = (bus.lu_res_rd != 5'd0); addr = bus.lu_res_rd; data = bus.lu_res_data;
            end
            check("cmp_stall", bus.pipe_stall, !reset && m_force);
            check("cmp_ready", bus.lu_res_ready, acc);
            check("cmp_wr_en", bus.rf_wr_en, en);
            if (en) begin
                check("cmp_wr_addr", bus.rf_wr_addr, addr);
                check("cmp_wr_data", bus.rf_wr_data, data);
            end
            check("cmp_rs_busy", bus.rs_busy,
                  !reset && m_busy[bus.rs_addr] && !(acc && bus.lu_res_rd == bus.rs_addr));
            check("cmp_rt_busy", bus.rt_busy,
                  !reset && m_busy[bus.rt_addr] && !(acc && bus.lu_res_rd == bus.rt_addr));
`ifdef RF_WB_STATS_EN
            check("cmp_conflict_cnt", conflict_cnt, m_conf);
            check("cmp_force_cnt", force_cnt, m_fcnt);
`endif
            if (!reset && bus.pipe_wb_valid)
                assert (!m_busy[bus.pipe_wb_rd])
                else $error("precondition broken: pipe writes busy r%0d", bus.pipe_wb_rd);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle_inputs();
        bus.pipe_wb_valid  = 1'b0; bus.pipe_wb_rd  = 5'd0; bus.pipe_wb_data = 32'd0;
        bus.lu_issue_valid = 1'b0; bus.lu_issue_rd = 5'd0;
        bus.lu_res_valid   = 1'b0; bus.lu_res_rd   = 5'd0; bus.lu_res_data  = 32'd0;
        bus.rs_addr        = 5'd0; bus.rt_addr     = 5'd0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
        #1;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
        bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = rd; bus.pipe_wb_data = d;
    endtask

    task automatic lu(input logic [4:0] rd, input logic [31:0] d);
        bus.lu_res_valid = 1'b1; bus.lu_res_rd = rd; bus.lu_res_data = d;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        pipe(5'd3, 32'h0000_0333);
        lu(5'd9, 32'h0000_0999);
        run = 1'b1;
        at_neg();
        check("rst_wr_en", bus.rf_wr_en, 32'd0);
        check("rst_ready", bus.lu_res_ready, 32'd0);
        check("rst_stall", bus.pipe_stall, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        idle_inputs();

        // lu alone gets the port immediately
        lu(5'd7, 32'h0000_1234);
        at_neg();
        check("lu_only_ready", bus.lu_res_ready, 32'd1);
        check("lu_only_en", bus.rf_wr_en, 32'd1);
        check("lu_only_addr", bus.rf_wr_addr, 32'd7);
        check("lu_only_data", bus.rf_wr_data, 32'h0000_1234);
        tick();
        idle_inputs();
        at_neg();
        check("lu_only_idle_stall", bus.pipe_stall, 32'd0);
        tick();

        // starvation: three denials then a forced grant
        pipe(5'd3, 32'hA0A0_0003);
        lu(5'd9, 32'h0000_0009);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("starve_pipe_addr", bus.rf_wr_addr, 32'd3);
            check("starve_lu_denied", bus.lu_res_ready, 32'd0);
            check("starve_no_stall", bus.pipe_stall, 32'd0);
            tick();
        end
        at_neg();
        check("force_stall", bus.pipe_stall, 32'd1);
        check("force_ready", bus.lu_res_ready, 32'd1);
        check("force_addr", bus.rf_wr_addr, 32'd9);
        check("force_data", bus.rf_wr_data, 32'h0000_0009);
        tick();
        bus.lu_res_valid = 1'b0;
        at_neg();
        check("after_force_stall", bus.pipe_stall, 32'd0);
        check("after_force_addr", bus.rf_wr_addr, 32'd3);
        check("after_force_en", bus.rf_wr_en, 32'd1);
        tick();
        idle_inputs();

        // scoreboard: r5 busy until its result is accepted
        bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd5;
        tick();
        bus.lu_issue_valid = 1'b0;
        bus.rs_addr = 5'd5;
        at_neg();
        check("sb_r5_busy0", bus.rs_busy, 32'd1);
        tick();
        at_neg();
        check("sb_r5_busy1", bus.rs_busy, 32'd1);
        tick();
        lu(5'd5, 32'h0000_0055);
        at_neg();
        check("sb_r5_bypass", bus.rs_busy, 32'd0);
        check("sb_r5_ready", bus.lu_res_ready, 32'd1);
        tick();
        bus.lu_res_valid = 1'b0;
        at_neg();
        check("sb_r5_free", bus.rs_busy, 32'd0);
        tick();

        // r0: handshake completes, no write, never marked busy
        lu(5'd0, 32'h0000_DEAD);
        at_neg();
        check("r0_ready", bus.lu_res_ready, 32'd1);
        check("r0_wr_en", bus.rf_wr_en, 32'd0);
        tick();
        idle_inputs();
        bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd0;
        tick();
        bus.lu_issue_valid = 1'b0;
        at_neg();
        check("r0_not_busy", bus.rs_busy, 32'd0);
        tick();

        // same-cycle set and clear of r12: set wins
        bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd12;
        tick();
        lu(5'd12, 32'h0000_0012);
        bus.rt_addr = 5'd12;
        at_neg();
        check("r12_accept", bus.lu_res_ready, 32'd1);
        check("r12_bypass", bus.rt_busy, 32'd0);
        tick();
        bus.lu_issue_valid = 1'b0;
        bus.lu_res_valid   = 1'b0;
        at_neg();
        check("r12_still_busy", bus.rt_busy, 32'd1);
        tick();
        lu(5'd12, 32'h0000_0C12);
        tick();
        bus.lu_res_valid = 1'b0;
        at_neg();
        check("r12_free", bus.rt_busy, 32'd0);
        tick();
        idle_inputs();

        // reset while waiting with two denials recorded
        bus.lu_issue_valid = 1'b1; bus.lu_issue_rd = 5'd20;
        tick();
        bus.lu_issue_valid = 1'b0;
        bus.rs_addr = 5'd20;
        pipe(5'd3, 32'h0000_0303);
        lu(5'd9, 32'h0000_0909);
        tick();
        tick();
        reset = 1'b1;
        at_neg();
        check("midrst_wr_en", bus.rf_wr_en, 32'd0);
        check("midrst_rs_busy", bus.rs_busy, 32'd0);
        tick();
        reset = 1'b0;
        at_neg();
        check("postrst_rs_busy", bus.rs_busy, 32'd0);
        check("postrst_ready", bus.lu_res_ready, 32'd0);
        check("postrst_stall", bus.pipe_stall, 32'd0);
        check("postrst_addr", bus.rf_wr_addr, 32'd3);
`ifdef RF_WB_STATS_EN
        check("postrst_conflict", conflict_cnt, 32'd0);
        check("postrst_force", force_cnt, 32'd0);
`endif
        tick();
        for (int i = 1; i < 3; i++) begin
            at_neg();
            check("postrst_wait_stall", bus.pipe_stall, 32'd0);
            tick();
        end
        at_neg();
        check("postrst_force_stall", bus.pipe_stall, 32'd1);
        check("postrst_force_addr", bus.rf_wr_addr, 32'd9);
        tick();
        idle_inputs();
        tick();
        tick();

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources:
  - the main pipeline writeback stage (pipe), which normally has priority;
  - a long-latency unit such as mul/div or a load miss (lu), which uses a valid/ready handshake.
- Guarantees lu forward progress by forcing a one-cycle pipeline stall after a bounded wait.
- Keeps a busy scoreboard of lu destinations so the decode/hazard logic can stall on RAW dependences.
- Sits between the execute/writeback stages and the register file write port.

Parameters:
- DATA_W, 32: register data width.
- ADDR_W, 5: register index width (2**ADDR_W registers).
- STARVE_LIMIT, 3: consecutive denied lu cycles before a forced grant; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pipe_wb_valid  in  1  pipeline has a result to write this cycle.
- pipe_wb_rd  in  ADDR_W  pipeline destination register.
- pipe_wb_data  in  DATA_W  pipeline result.
- pipe_stall  out  1  freezes the pipeline; the writeback stage re-presents the same result next cycle.
- lu_issue_valid  in  1  an lu operation is issued this cycle.
- lu_issue_rd  in  ADDR_W  destination of the issued lu operation.
- lu_res_valid  in  1  lu result pending; held stable until accepted.
- lu_res_rd  in  ADDR_W  lu result destination.
- lu_res_data  in  DATA_W  lu result value.
- lu_res_ready  out  1  lu result accepted this cycle.
- rs_addr, rt_addr  in  ADDR_W  decode-stage source registers.
- rs_busy, rt_busy  out  1  source register awaits an lu result.
- rf_wr_en  out  1  register file write enable.
- rf_wr_addr  out  ADDR_W  register file write index.
- rf_wr_data  out  DATA_W  register file write value.

Behaviour:
- Reset (synchronous, active-high):
  - State registers: FSM=IDLE, wait_cnt=0, busy=0.
  - While reset=1, these outputs are forced to 0: rf_wr_en, lu_res_ready, pipe_stall, rs_busy, rt_busy.
  - Reset mid-handshake drops the pending lu grant; the lu must re-present its result after reset.
- Write-port timing:
  - The write port is combinational from the current inputs and registered state (zero latency).
  - The register file commits the write on the next clock edge.
- FSM states:
  - IDLE: no lu result waiting.
  - WAIT: lu result denied at least once.
  - FORCE: one-cycle forced lu grant.
- Grant rule:
  - pipe wins if pipe_wb_valid=1 and state!=FORCE.
  - Otherwise lu wins if lu_res_valid=1.
  - lu_res_ready = lu granted.
- Write port contents:
  - Mux of the granted source.
  - rf_wr_en = grant & (rd!=0). A write to r0 is dropped, but the handshake still completes.
- wait_cnt:
  - Increments each cycle lu_res_valid=1 and lu_res_ready=0.
  - Clears on any lu grant.
- FSM transitions:
  - IDLE->WAIT on the first denial.
  - WAIT->IDLE on an lu grant.
  - WAIT->FORCE when a denial occurs with wait_cnt==STARVE_LIMIT-1.
  - FORCE->IDLE unconditionally after one cycle.
- In FORCE:
  - pipe_stall=1, lu granted, pipe write suppressed.
  - The pipeline holds pipe_wb_* and retries next cycle.
  - pipe_stall=0 in all other states.
- Worst-case lu wait is STARVE_LIMIT cycles, then the grant.
- Scoreboard:
  - busy[lu_issue_rd] set on lu_issue_valid, except for rd=0.
  - busy[lu_res_rd] cleared on lu acceptance.
  - Same-cycle set and clear of the same rd: set wins.
- rs_busy = busy[rs_addr] & ~(lu accepted this cycle with lu_res_rd==rs_addr). The register file forwards same-cycle writes, so a register being written this cycle is not reported busy. Same rule for rt.
- Precondition: pipe_wb_rd never targets a busy register. The bench checks this with an assertion; the RTL does not handle it.

Optional Feature:
- RF_WB_STATS_EN defined:
  - Adds outputs conflict_cnt[15:0] (cycles lu was denied) and force_cnt[15:0] (FORCE entries).
  - Both counters saturate at 16'hFFFF and clear on reset.
- RF_WB_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package rf_wb_pkg:
  - State enum {IDLE, WAIT, FORCE}.
  - Constants DATA_W, ADDR_W, REG_ZERO=0.
- Sub-module rf_scoreboard:
  - Contains the busy vector with set/clear logic and the two query ports with same-cycle clear bypass.
  - Instantiated once.

Test Plan:
- Only lu_res_valid=1 with rd=7, data=32'h1234 and pipe idle -> same cycle: lu_res_ready=1, rf_wr_en=1, addr=7, data=32'h1234; FSM stays IDLE.
- pipe_wb_valid held 1 (rd=3), lu_res_valid=1 (rd=9), STARVE_LIMIT=3 -> cycles 0-2: pipe writes r3, lu denied; cycle 3: pipe_stall=1, r9 written, lu_res_ready=1; cycle 4: pipe writes r3 again, pipe_stall=0.
- lu_issue_valid with rd=5, then rs_addr=5 -> rs_busy=1 until the lu result for r5 is accepted; rs_busy=0 in the acceptance cycle itself.
- lu result with rd=0 -> lu_res_ready=1, rf_wr_en=0; lu_issue_valid with rd=0 leaves busy[0]=0.
- Same-cycle lu_issue_rd=12 and lu result accept for rd=12 -> busy[12] stays 1 next cycle.
- reset asserted in WAIT with wait_cnt=2 -> next cycle FSM=IDLE, busy=0, all outputs 0; with RF_WB_STATS_EN, counters read 0.
